// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku grid self-check engine.
package sudoku_pkg;

  localparam int N_CELLS = 81;
  localparam int GRID    = 9;
  localparam int BOX     = 3;
  localparam int CELL_AW = 7;

  typedef logic [CELL_AW-1:0] cell_addr_t;
  typedef logic [3:0]         digit_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RANGE = 3'd1,
    ERR_GIVEN = 3'd2,
    ERR_ROW   = 3'd3,
    ERR_COL   = 3'd4,
    ERR_BOX   = 3'd5
  } chk_err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/sudoku_digit_dec.sv
// Cell value decoder: DW-bit value to a one-hot digit (bit k = digit k+1).
// Out-of-range values (0, >9, or nonzero upper bits) decode to all-zero.
module sudoku_digit_dec
  import sudoku_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0]   val,
  output logic [GRID-1:0] onehot,
  output logic            in_range
);

  digit_t d;
  assign d = val[3:0];

  // Range test and one-hot expansion.
  always_comb begin
    in_range = (val[DW-1:4] == '0) && (d != 4'd0) && (d <= digit_t'(GRID));
    onehot   = '0;
    for (int k = 0; k < GRID; k++) begin
      onehot[k] = in_range && (d == digit_t'(k + 1));
    end
  end

endmodule

// File: rtl/sudoku_checker.sv
// Reads back an 81-cell solved grid from the result RAM alongside the puzzle
// ROM and reports whether it is a valid solution plus the first failing cell.
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | issuing cell addresses 0..80, one per cycle
// DRAIN | no new read; last cell's data is being checked
// DONE  | result held; start begins a new pass
module sudoku_checker
  import sudoku_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ROM_rd,
  output logic [AW-1:0] ROM_A,
  input  logic [DW-1:0] ROM_Q,
  output logic          RAM_ceb,
  output logic          RAM_web,
  output logic [AW-1:0] RAM_A,
  input  logic [DW-1:0] RAM_Q,
  output logic          done,
  output logic          valid,
  output logic [2:0]    err_code,
  output logic [AW-1:0] err_addr
);

  localparam logic [AW-1:0] LAST_CELL = AW'(N_CELLS - 1);

  chk_state_e      state;
  logic [AW-1:0]   addr_q;
  logic            rd_q, ceb_q, done_q, valid_q;
  logic [3:0]      col, row;
  logic [1:0]      col_sub, row_sub, bcol, brow;
  logic [3:0]      box_idx;
  logic            go;

  logic            s1_vld;
  logic [AW-1:0]   s1_addr;
  logic [3:0]      s1_row, s1_col, s1_box;

  logic [GRID-1:0] row_m [GRID];
  logic [GRID-1:0] col_m [GRID];
  logic [GRID-1:0] box_m [GRID];
  chk_err_e        err_code_q, cell_err;
  logic [AW-1:0]   err_addr_q;

  logic [GRID-1:0] dig_oh;
  logic            dig_ok;

  assign go       = start && ((state == IDLE) || (state == DONE));
  // box = 3*box_row + box_col, built from the sub-counters with adds only
  assign box_idx  = {2'b00, brow} + {1'b0, brow, 1'b0} + {2'b00, bcol};

  assign ROM_rd   = rd_q;
  assign ROM_A    = addr_q;
  assign RAM_ceb  = ceb_q;
  assign RAM_web  = 1'b1;
  assign RAM_A    = addr_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

  // Sequencer and stage 0: issue one address per cycle and track row/col/box.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      ceb_q   <= 1'b1;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      col     <= '0;
      row     <= '0;
      col_sub <= '0;
      row_sub <= '0;
      bcol    <= '0;
      brow    <= '0;
    end else if (go) begin
      state   <= SCAN;
      addr_q  <= '0;
      rd_q    <= 1'b1;
      ceb_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      col     <= '0;
      row     <= '0;
      col_sub <= '0;
      row_sub <= '0;
      bcol    <= '0;
      brow    <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (addr_q == LAST_CELL) begin
            state <= DRAIN;
            rd_q  <= 1'b0;
            ceb_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (col == 4'(GRID - 1)) begin
              col     <= '0;
              col_sub <= '0;
              bcol    <= '0;
              row     <= row + 4'd1;
              if (row_sub == 2'(BOX - 1)) begin
                row_sub <= '0;
                brow    <= brow + 2'd1;
              end else begin
                row_sub <= row_sub + 2'd1;
              end
            end else begin
              col <= col + 4'd1;
              if (col_sub == 2'(BOX - 1)) begin
                col_sub <= '0;
                bcol    <= bcol + 2'd1;
              end else begin
                col_sub <= col_sub + 2'd1;
              end
            end
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          valid_q <= (err_code_q == ERR_NONE);
        end
        default: ;
      endcase
    end
  end

  // Stage 1 alignment: indices follow the address by one cycle to meet the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_box  <= '0;
    end else begin
      s1_vld  <= rd_q;
      s1_addr <= addr_q;
      s1_row  <= row;
      s1_col  <= col;
      s1_box  <= box_idx;
    end
  end

  sudoku_digit_dec #(.DW(DW)) u_dec (
    .val      (RAM_Q),
    .onehot   (dig_oh),
    .in_range (dig_ok)
  );

  // Per-cell check with fixed priority; an out-of-range digit has a zero
  // one-hot so it can never also report a duplicate.
  always_comb begin
    cell_err = ERR_NONE;
    if (!dig_ok)                                  cell_err = ERR_RANGE;
    else if (ROM_Q != '0 && ROM_Q != RAM_Q)       cell_err = ERR_GIVEN;
    else if (|(row_m[s1_row] & dig_oh))           cell_err = ERR_ROW;
    else if (|(col_m[s1_col] & dig_oh))           cell_err = ERR_COL;
    else if (|(box_m[s1_box] & dig_oh))           cell_err = ERR_BOX;
  end

  // Masks accumulate every in-range digit; only the first error is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < GRID; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else if (go) begin
      for (int i = 0; i < GRID; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else if (s1_vld) begin
      row_m[s1_row] <= row_m[s1_row] | dig_oh;
      col_m[s1_col] <= col_m[s1_col] | dig_oh;
      box_m[s1_box] <= box_m[s1_box] | dig_oh;
      if (err_code_q == ERR_NONE && cell_err != ERR_NONE) begin
        err_code_q <= cell_err;
        err_addr_q <= s1_addr;
      end
    end
  end

endmodule

// File: doc/sudoku_checker.md
Name: sudoku_checker

Overview:
- Read-side counterpart to the Sudoku solver: after the solver writes its 81-cell grid into the result RAM, this block reads the grid back.
- It reads the puzzle ROM over the same ROM/RAM protocol the solver uses.
- Each cell is checked for digit range, agreement with the given clues, and uniqueness within its row, column and 3x3 box.
- It reports pass/fail plus the first failing cell. It sits beside the solver as a self-check engine and arbitrates nothing.

Parameters:
DW, 8, ROM/RAM data width (digit held in bits [3:0], upper bits must be 0)
AW, 7, ROM/RAM address width (cells 0..80, row-major, addr = row*9+col)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin a check pass (sampled in IDLE or DONE only)
ROM_rd  out  1  ROM read strobe, active-high
ROM_A  out  AW  ROM address
ROM_Q  in  DW  ROM data, valid 1 cycle after ROM_rd
RAM_ceb  out  1  RAM chip enable, active-low
RAM_web  out  1  RAM write enable, active-low; tied high (read-only)
RAM_A  out  AW  RAM address
RAM_Q  in  DW  RAM data, valid 1 cycle after ceb low
done  out  1  level; high in DONE until next start
valid  out  1  grid correct; meaningful only when done=1
err_code  out  3  first error type (see below)
err_addr  out  AW  address of first failing cell

Behaviour:
- Reset (rst=0, any time including mid-scan): state IDLE; ROM_rd=0, ROM_A=0, RAM_ceb=1, RAM_web=1, RAM_A=0, done=0, valid=0, err_code=0, err_addr=0; all masks and counters cleared.
- States:
  - IDLE: start=1 -> SCAN.
  - SCAN: issue address c=0..80, one per cycle; ROM_rd=1 and RAM_ceb=0 with ROM_A=RAM_A=c. After c=80 -> DRAIN.
  - DRAIN: ROM_rd=0, RAM_ceb=1; check the last cell -> DONE.
  - DONE: done=1; start=1 -> SCAN, clearing masks, error regs and done on the same edge.
- start is ignored in SCAN and DRAIN.
- Pipeline is 2 stages:
  - Stage 0 issues address c and latches row/col/box indices.
  - Stage 1 receives ROM_Q/RAM_Q for cell c one cycle later and performs the checks.
- Latency: start sampled at edge 0 -> done=1 after edge 83, i.e. 81 issue cycles + 1 drain + 1 register.
- Indices are produced by counters (col 0..8, row 0..8, box-col 0..2 and box-row 0..2 sub-counters), never by division. box = 3*(row/3)+(col/3).
- Masks: row_m[9], col_m[9], box_m[9], each 9 bits one-hot by digit. A mask bit is set for every in-range cell, even one that fails another check.
- Per-cell checks, with priority when several fire on the same cell (highest first):
  - 1 RANGE: RAM digit not in 1..9, or RAM_Q[7:4]!=0.
  - 2 GIVEN: ROM_Q!=0 and ROM_Q!=RAM_Q.
  - 3 ROW_DUP: digit already set in row_m[row].
  - 4 COL_DUP: digit already set in col_m[col].
  - 5 BOX_DUP: digit already set in box_m[box].
- err_code=0 means no error.
- Only the first failing cell (lowest address) is recorded. The scan always runs to completion, so latency is fixed.
- Duplicates are flagged at the second occurrence.
- In DONE: valid=1 iff no error was recorded.
- ROM values >9 are treated as GIVEN mismatch unless they equal RAM_Q. No separate code exists for ROM values >9.

Decomposition:
- Shared package sudoku_pkg holds:
  - constants N_CELLS=81, GRID=9, BOX=3
  - typedef cell_addr_t (AW bits) and digit_t (4 bits)
  - enum chk_err_e {ERR_NONE, ERR_RANGE, ERR_GIVEN, ERR_ROW, ERR_COL, ERR_BOX}
  - enum chk_state_e {IDLE, SCAN, DRAIN, DONE}
- Sub-module sudoku_digit_dec (combinational): DW-bit value -> 9-bit one-hot plus in_range flag. Used once for RAM_Q.

Test Plan:
- Solved tb1 grid in RAM, matching puzzle in ROM, start -> done rises 83 cycles later, valid=1, err_code=0, RAM_web stays 1 throughout.
- Correct grid, ROM[0]=0, RAM[0] overwritten with RAM[1] value -> err_code=ROW(3), err_addr=1, valid=0, done still at cycle 83.
- RAM[40]=8'd0 -> err_code=RANGE(1), err_addr=40. Repeat with RAM[40]=8'h1A -> same result.
- ROM[5]=7, RAM[5]=3; the 3 also duplicates in row 0 -> err_code=GIVEN(2), err_addr=5 (priority over ROW).
- Two errors: col dup at addr 9, range error at 60 -> err_code=COL(4), err_addr=9 (first wins).
- rst pulsed low at scan cell 30 -> all outputs at reset values within the same cycle. A new start on a good grid -> valid=1. start asserted again at SCAN cell 10 -> ignored, done still at 83. start in DONE -> done=0 next cycle and re-run passes.
